// File: rtl/uncached_access_unit_pkg.sv
// Shared types for the uncached access path: MMU result, buffered request, FSM state.
package uncached_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] phy_addr;
    logic        uncached;
  } mmu_result_t;

  typedef struct packed {
    logic [31:0] phy_addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } uncached_req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_ADDR,
    S_W_DATA,
    S_R_ADDR,
    S_R_DATA
  } ucs_state_t;

  // True while a posted store owns the bus.
  function automatic logic is_write_phase(input ucs_state_t s);
    return (s == S_W_ADDR) || (s == S_W_DATA);
  endfunction

endpackage

// File: rtl/uncached_access_unit_if.sv
// SRAM-like single-outstanding bus between the uncached unit and memory.
interface uncached_access_unit_if;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/uncached_access_unit_wbuf.sv
// Posted-store FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate count.
module uncached_wbuf
  import uncached_access_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  uncached_req_t push_data,
  input  logic          pop,
  output uncached_req_t head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  uncached_req_t mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  // Pointer update; push into a full buffer or pop from an empty one is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uncached_access_unit.sv
// Uncached access unit: posts stores into a write buffer, drains it ahead of
// any pending load, and runs one bus transaction at a time.
module uncached_access_unit
  import uncached_access_unit_pkg::*;
#(
  parameter int WBUF_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  mmu_result_t            req_result,
  input  logic                   req_ex,
  input  logic                   req_wr,
  input  logic [1:0]             req_size,
  input  logic [3:0]             req_wstrb,
  input  logic [31:0]            req_wdata,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  input  logic                   flush,
  output logic                   wbuf_empty,
  uncached_access_unit_if.master bus
);

  ucs_state_t    state;
  logic          load_pending;
  logic          killed;
  logic [31:0]   ld_addr;
  logic [1:0]    ld_size;

  logic          wb_full;
  logic          wb_empty;
  logic          wb_pop;
  uncached_req_t wb_head;
  uncached_req_t wb_in;

  logic          accept;
  logic          st_push;
  logic          ld_accept;

  assign req_ready  = ~wb_full & ~load_pending;
  assign accept     = req_valid & req_ready & req_result.uncached & ~req_ex;
  assign st_push    = accept & req_wr;
  assign ld_accept  = accept & ~req_wr & ~flush;
  assign wb_pop     = (state == S_W_ADDR) & bus.bus_addr_ok;
  assign wbuf_empty = wb_empty & ~is_write_phase(state);

  assign wb_in = '{phy_addr: req_result.phy_addr, size: req_size,
                   wstrb: req_wstrb, wdata: req_wdata};

  uncached_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (st_push),
    .push_data (wb_in),
    .pop       (wb_pop),
    .head      (wb_head),
    .full      (wb_full),
    .empty     (wb_empty)
  );

  // Load register capture; only meaningful while load_pending is set.
  always_ff @(posedge clk) begin
    if (ld_accept) begin
      ld_addr <= req_result.phy_addr;
      ld_size <= req_size;
    end
  end

  // Bus FSM with registered bus and response outputs. Flush handling comes
  // first so that a same-cycle read return takes priority over setting killed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      load_pending   <= 1'b0;
      killed         <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      bus.bus_req    <= 1'b0;
      bus.bus_wr     <= 1'b0;
      bus.bus_size   <= '0;
      bus.bus_addr   <= '0;
      bus.bus_wstrb  <= '0;
      bus.bus_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;

      if (ld_accept)
        load_pending <= 1'b1;

      if (flush) begin
        if (state == S_R_ADDR || state == S_R_DATA)
          killed <= 1'b1;
        else
          load_pending <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!wb_empty) begin
            state         <= S_W_ADDR;
            bus.bus_req   <= 1'b1;
            bus.bus_wr    <= 1'b1;
            bus.bus_size  <= wb_head.size;
            bus.bus_addr  <= wb_head.phy_addr;
            bus.bus_wstrb <= wb_head.wstrb;
            bus.bus_wdata <= wb_head.wdata;
          end else if (load_pending && !flush) begin
            state         <= S_R_ADDR;
            bus.bus_req   <= 1'b1;
            bus.bus_wr    <= 1'b0;
            bus.bus_size  <= ld_size;
            bus.bus_addr  <= ld_addr;
            bus.bus_wstrb <= 4'h0;
            bus.bus_wdata <= '0;
          end
        end
        S_W_ADDR: begin
          if (bus.bus_addr_ok) begin
            state       <= S_W_DATA;
            bus.bus_req <= 1'b0;
          end
        end
        S_W_DATA: begin
          if (bus.bus_data_ok)
            state <= S_IDLE;
        end
        S_R_ADDR: begin
          if (bus.bus_addr_ok) begin
            state       <= S_R_DATA;
            bus.bus_req <= 1'b0;
          end
        end
        S_R_DATA: begin
          if (bus.bus_data_ok) begin
            state        <= S_IDLE;
            load_pending <= 1'b0;
            killed       <= 1'b0;
            resp_valid   <= ~(killed | flush);
            resp_rdata   <= bus.bus_rdata;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uncached_access_unit.sv
// Bench for uncached_access_unit: directed scenarios plus a random access mix,
// checked against a program-order memory/transaction model.
module tb_uncached_access_unit;
  import uncached_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  mmu_result_t req_result;
  logic        req_ex;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        flush;
  logic        wbuf_empty;

  always #5 clk = ~clk;

  uncached_access_unit_if bus_if();

  uncached_access_unit #(.WBUF_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_result (req_result),
    .req_ex     (req_ex),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_wstrb  (req_wstrb),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .flush      (flush),
    .wbuf_empty (wbuf_empty),
    .bus        (bus_if)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  bus_t        obs_bus[$];
  bus_t        ref_bus[$];
  logic [31:0] resp_q[$];
  logic [31:0] ref_resp[$];
  logic [31:0] mem_rsp [bit [29:0]];
  logic [31:0] ref_mem [bit [29:0]];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int resp_cyc = -1;
  int wdone_cyc = -1;
  int busreq_cycles = 0;
  int obs_base = 0;
  int resp_base = 0;
  int adly = 0;
  int ddly = 0;
  bit rnd = 1'b0;
  bit stall = 1'b0;
  bit unstable = 1'b0;
  int rsp_phase = 0;

  function automatic logic [31:0] dflt(input bit [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h5A00_00A5;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rsp_rd(input bit [29:0] w);
    return mem_rsp.exists(w) ? mem_rsp[w] : dflt(w);
  endfunction

  function automatic logic [31:0] ref_rd(input bit [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
  endfunction

  // Memory-side responder: configurable address/data latency, stall, and a stability watch.
  initial begin
    bus_t     cur;
    bus_t     snap;
    bit       seen;
    int       cnt;
    int       a_cur;
    int       d_cur;
    bit       cur_wr;
    bit [29:0] cur_w;
    seen = 1'b0; cnt = 0; a_cur = 0; d_cur = 0; cur_wr = 1'b0; cur_w = '0;
    mem_rsp[30'(32'h1FD0_0000 >> 2)] = 32'hDEAD_BEEF;
    bus_if.bus_addr_ok = 1'b0;
    bus_if.bus_data_ok = 1'b0;
    bus_if.bus_rdata   = '0;
    forever begin
      @(posedge clk); #2;
      bus_if.bus_addr_ok = 1'b0;
      bus_if.bus_data_ok = 1'b0;
      bus_if.bus_rdata   = $urandom;
      if (reset) begin
        rsp_phase = 0; seen = 1'b0; cnt = 0;
        continue;
      end
      if (rsp_phase == 0) begin
        if (bus_if.bus_req) begin
          cur.wr = bus_if.bus_wr;       cur.addr  = bus_if.bus_addr;
          cur.size = bus_if.bus_size;   cur.wstrb = bus_if.bus_wstrb;
          cur.wdata = bus_if.bus_wdata;
          if (!seen) begin
            snap = cur; seen = 1'b1; cnt = 0;
            a_cur = rnd ? int'($urandom_range(0, 3)) : adly;
            d_cur = rnd ? int'($urandom_range(0, 3)) : ddly;
          end else if (cur !== snap) begin
            unstable = 1'b1;
          end
          if (!stall && cnt >= a_cur) begin
            bus_if.bus_addr_ok = 1'b1;
            obs_bus.push_back(cur);
            cur_wr = cur.wr;
            cur_w  = cur.addr[31:2];
            if (cur.wr) mem_rsp[cur_w] = merge(rsp_rd(cur_w), cur.wdata, cur.wstrb);
            rsp_phase = 1; cnt = 0; seen = 1'b0;
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cnt >= d_cur) begin
          bus_if.bus_data_ok = 1'b1;
          if (!cur_wr) bus_if.bus_rdata = rsp_rd(cur_w);
          else         wdone_cyc = cyc;
          rsp_phase = 0; cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Output monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (resp_valid) begin
      resp_q.push_back(resp_rdata);
      resp_cyc = cyc;
    end
    if (bus_if.bus_req) busreq_cycles++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until the unit is ready; returns after the accepting edge.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [3:0] strb, input logic [31:0] data,
                       input bit uc, input bit ex);
    int n;
    req_valid = 1'b1; req_wr = wr; req_result.phy_addr = addr; req_result.uncached = uc;
    req_ex = ex; req_size = size; req_wstrb = strb; req_wdata = data;
    n = 0;
    while (!req_ready && n < 300) begin tick(); n++; end
    if (n >= 300) chk("issue_ready_timeout", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [3:0] strb,
                          input logic [31:0] data, input bit uc, input bit ex);
    issue(1'b1, addr, size, strb, data, uc, ex);
    if (uc && !ex) begin
      ref_bus.push_back('{wr: 1'b1, addr: addr, size: size, wstrb: strb, wdata: data});
      ref_mem[addr[31:2]] = merge(ref_rd(addr[31:2]), data, strb);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input bit uc, input bit ex);
    issue(1'b0, addr, size, 4'h0, $urandom, uc, ex);
    if (uc && !ex) begin
      ref_bus.push_back('{wr: 1'b0, addr: addr, size: size, wstrb: 4'h0, wdata: 32'h0});
      ref_resp.push_back(ref_rd(addr[31:2]));
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(wbuf_empty && req_ready && !bus_if.bus_req && rsp_phase == 0) && n < 1000) begin
      tick(); n++;
    end
    repeat (3) tick();
    chk({tag, "_drain"}, (n < 1000), 1'b1);
  endtask

  task automatic compare_logs(input string tag);
    int nb;
    int nr;
    bus_t o;
    bus_t r;
    nb = obs_bus.size() - obs_base;
    nr = resp_q.size() - resp_base;
    chk({tag, "_nbus"}, nb, ref_bus.size());
    for (int i = 0; i < nb && i < ref_bus.size(); i++) begin
      o = obs_bus[obs_base + i];
      r = ref_bus[i];
      chk($sformatf("%s_wr%0d", tag, i), o.wr, r.wr);
      chk($sformatf("%s_addr%0d", tag, i), o.addr, r.addr);
      chk($sformatf("%s_size%0d", tag, i), o.size, r.size);
      chk($sformatf("%s_wstrb%0d", tag, i), o.wstrb, r.wstrb);
      if (r.wr) chk($sformatf("%s_wdata%0d", tag, i), o.wdata, r.wdata);
    end
    chk({tag, "_nresp"}, nr, ref_resp.size());
    for (int i = 0; i < nr && i < ref_resp.size(); i++)
      chk($sformatf("%s_rdata%0d", tag, i), resp_q[resp_base + i], ref_resp[i]);
    obs_base  = obs_bus.size();
    resp_base = resp_q.size();
    ref_bus.delete();
    ref_resp.delete();
  endtask

  initial begin
    int b0;
    int n;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_result = '0; req_ex = 1'b0;
    req_wr = 1'b0; req_size = SIZE_WORD; req_wstrb = 4'h0; req_wdata = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_wbuf_empty", wbuf_empty, 1'b1);
    chk("rst_bus_req", bus_if.bus_req, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_bus_wstrb", bus_if.bus_wstrb, 4'h0);
    reset = 1'b0;
    tick();

    // 1) Single load with delayed addr_ok/data_ok
    adly = 2; ddly = 2;
    issue(1'b0, 32'h1FD0_0000, SIZE_WORD, 4'h0, 32'h0, 1'b1, 1'b0);
    drain("t1");
    ref_bus.push_back('{wr: 1'b0, addr: 32'h1FD0_0000, size: SIZE_WORD, wstrb: 4'h0, wdata: 32'h0});
    ref_resp.push_back(32'hDEAD_BEEF);
    compare_logs("t1");

    // 2) Four stores with the bus stalled fill the buffer
    adly = 0; ddly = 1; stall = 1'b1;
    for (int i = 0; i < 4; i++)
      do_store(32'h1FAF_F000 + 32'(4 * i), SIZE_WORD, 4'hF, $urandom, 1'b1, 1'b0);
    chk("t2_ready_full", req_ready, 1'b0);
    chk("t2_wbuf_empty_busy", wbuf_empty, 1'b0);
    req_valid = 1'b1; req_wr = 1'b1; req_result.phy_addr = 32'h1FAF_F010;
    req_result.uncached = 1'b1; req_ex = 1'b0; req_wstrb = 4'hF; req_wdata = 32'h5555_AAAA;
    repeat (3) tick();
    chk("t2_ready_5th", req_ready, 1'b0);
    req_valid = 1'b0;
    stall = 1'b0;
    drain("t2");
    chk("t2_wbuf_empty_done", wbuf_empty, 1'b1);
    compare_logs("t2");

    // 3) Store then load to the same word: write first, response after write completes
    adly = 1; ddly = 3;
    do_store(32'h1FAF_F010, SIZE_HALF, 4'h3, 32'h1234_ABCD, 1'b1, 1'b0);
    do_load(32'h1FAF_F010, SIZE_WORD, 1'b1, 1'b0);
    drain("t3");
    chk("t3_resp_after_wdone", (resp_cyc > wdone_cyc), 1'b1);
    compare_logs("t3");

    // 4) Flush while the read is in its data phase
    adly = 0; ddly = 6;
    b0 = obs_bus.size();
    issue(1'b0, 32'h1FD0_0040, SIZE_WORD, 4'h0, 32'h0, 1'b1, 1'b0);
    ref_bus.push_back('{wr: 1'b0, addr: 32'h1FD0_0040, size: SIZE_WORD, wstrb: 4'h0, wdata: 32'h0});
    n = 0;
    while (obs_bus.size() == b0 && n < 100) begin tick(); n++; end
    chk("t4_read_seen", (obs_bus.size() > b0), 1'b1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4_ready_held", req_ready, 1'b0);
    drain("t4");
    chk("t4_ready_back", req_ready, 1'b1);
    compare_logs("t4");
    ddly = 1;
    do_load(32'h1FD0_0044, SIZE_WORD, 1'b1, 1'b0);
    drain("t4b");
    compare_logs("t4b");

    // Flush while the load waits behind a posted store
    stall = 1'b1;
    do_store(32'h1FAF_F004, SIZE_BYTE, 4'h4, 32'h00C3_0000, 1'b1, 1'b0);
    issue(1'b0, 32'h1FAF_F004, SIZE_WORD, 4'h0, 32'h0, 1'b1, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4c_ready_after_drop", req_ready, 1'b1);
    chk("t4c_wbuf_pending", wbuf_empty, 1'b0);
    stall = 1'b0;
    drain("t4c");
    compare_logs("t4c");

    // Flush coinciding with a load accept
    flush = 1'b1;
    issue(1'b0, 32'h1FAF_F008, SIZE_WORD, 4'h0, 32'h0, 1'b1, 1'b0);
    flush = 1'b0;
    tick();
    chk("t4d_ready", req_ready, 1'b1);
    drain("t4d");
    compare_logs("t4d");

    // 5) Cached or excepting requests are ignored
    b0 = busreq_cycles;
    issue(1'b1, 32'h1FAF_F000, SIZE_WORD, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(1'b0, 32'h1FAF_F000, SIZE_WORD, 4'h0, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 32'h1FAF_F000, SIZE_WORD, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    repeat (5) tick();
    chk("t5_busreq_cycles", busreq_cycles - b0, 0);
    chk("t5_wbuf_empty", wbuf_empty, 1'b1);
    compare_logs("t5");

    // 6) Reset while a write waits for data_ok with two more entries queued
    adly = 0; ddly = 20; stall = 1'b1;
    for (int i = 0; i < 3; i++)
      issue(1'b1, 32'h1FB0_0000 + 32'(4 * i), SIZE_WORD, 4'hF, $urandom, 1'b1, 1'b0);
    b0 = obs_bus.size();
    stall = 1'b0;
    n = 0;
    while (obs_bus.size() == b0 && n < 100) begin tick(); n++; end
    stall = 1'b1;
    chk("t6_write_started", (obs_bus.size() > b0), 1'b1);
    tick();
    reset = 1'b1; tick();
    chk("t6_bus_req", bus_if.bus_req, 1'b0);
    chk("t6_wbuf_empty", wbuf_empty, 1'b1);
    chk("t6_ready", req_ready, 1'b1);
    chk("t6_resp_valid", resp_valid, 1'b0);
    chk("t6_bus_addr", bus_if.bus_addr, 32'h0);
    reset = 1'b0; stall = 1'b0; ddly = 1;
    obs_base  = obs_bus.size();
    resp_base = resp_q.size();
    tick();
    do_store(32'h1FAF_F020, SIZE_WORD, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0);
    drain("t6");
    compare_logs("t6");

    // Random mix against the program-order model
    rnd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [1:0]  s;
      bit          uc;
      bit          ex;
      a  = 32'h1FAF_F000 + 32'(4 * $urandom_range(0, 7));
      s  = 2'($urandom_range(0, 2));
      uc = ($urandom_range(0, 7) != 0);
      ex = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) < 6)
        do_store(a, s, 4'($urandom), $urandom, uc, ex);
      else
        do_load(a, s, uc, ex);
    end
    drain("rnd");
    compare_logs("rnd");
    chk("bus_stable_while_waiting", unstable, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
